// File: rtl/aes_pkg.sv
// aes_pkg: shared AES-128 constants, FSM encoding and GF(2^8) round helpers
package aes_pkg;

    localparam int         AES_BLOCK_W = 128;
    localparam logic [7:0] RCON_INIT   = 8'h01;

    typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            p = b[i] ? p ^ x : p;
            x = xtime(x);
        end
        return p;
    endfunction

    // inverse computed as a^254 (zero maps to zero), then the affine map
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] sq, inv;
        sq  = a;
        inv = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                   ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        logic [31:0] o;
        for (int i = 0; i < 4; i++) o[8*i +: 8] = sbox(w[8*i +: 8]);
        return o;
    endfunction

    function automatic logic [AES_BLOCK_W-1:0] sub_bytes(input logic [AES_BLOCK_W-1:0] s);
        logic [AES_BLOCK_W-1:0] o;
        for (int i = 0; i < 16; i++) o[8*i +: 8] = sbox(s[8*i +: 8]);
        return o;
    endfunction

    // byte n sits at bits [127-8n -: 8], with n = row + 4*col
    function automatic logic [AES_BLOCK_W-1:0] shift_rows(input logic [AES_BLOCK_W-1:0] s);
        logic [AES_BLOCK_W-1:0] o;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+r)%4)) -: 8];
        return o;
    endfunction

    function automatic logic [AES_BLOCK_W-1:0] mix_columns(input logic [AES_BLOCK_W-1:0] s);
        logic [AES_BLOCK_W-1:0] o;
        logic [7:0] a [4];
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) a[r] = s[127-8*(4*c+r) -: 8];
            for (int r = 0; r < 4; r++)
                o[127-8*(4*c+r) -: 8] = xtime(a[r] ^ a[(r+1)%4]) ^ a[(r+1)%4] ^ a[(r+2)%4] ^ a[(r+3)%4];
        end
        return o;
    endfunction

endpackage

// File: rtl/aes_key_step.sv
// aes_key_step: one combinational AES-128 key-expansion step (RotWord, SubWord, Rcon, XOR chain)
module aes_key_step
    import aes_pkg::*;
(
    input  logic [AES_BLOCK_W-1:0] key_i,
    input  logic [7:0]             rcon_i,
    output logic [AES_BLOCK_W-1:0] key_o
);

    logic [31:0] t, w0, w1, w2;

    always_comb begin
        t     = sub_word({key_i[23:0], key_i[31:24]}) ^ {rcon_i, 24'h0};
        w0    = key_i[127:96] ^ t;
        w1    = key_i[95:64] ^ w0;
        w2    = key_i[63:32] ^ w1;
        key_o = {w0, w1, w2, key_i[31:0] ^ w2};
    end

endmodule

// File: rtl/aes_round_scheduler.sv
// aes_round_scheduler: iterative AES-128 encryptor, one round per clock with on-the-fly key expansion.
// Optional completed-block counter port enabled by AES_ROUND_SCHEDULER_STATS_EN.
module aes_round_scheduler
    import aes_pkg::*;
#(
    parameter int Nk = 4,
    parameter int Nr = 10
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [AES_BLOCK_W-1:0] data_in,
    input  logic [Nk*32-1:0]       key,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [AES_BLOCK_W-1:0] data_out,
`ifdef AES_ROUND_SCHEDULER_STATS_EN
    output logic [31:0]            blocks_done,
`endif
    output logic                   busy
);

    localparam logic [3:0] NR_L = 4'(Nr);

    if (Nk != 4 || Nr != Nk + 6) begin : g_bad_cfg
        $error("aes_round_scheduler supports only Nk=4, Nr=10");
    end

    state_t fsm_q, fsm_d;
    logic [AES_BLOCK_W-1:0] blk_q, blk_d, key_q, key_d, dout_q, dout_d, key_nxt, sr, res;
    logic [7:0] rcon_q, rcon_d;
    logic [3:0] rnd_q, rnd_d;
    logic accept, rnd_ok, last;

    aes_key_step u_key_step (.key_i(key_q), .rcon_i(rcon_q), .key_o(key_nxt));

    assign accept = fsm_q == IDLE && in_valid;
    assign rnd_ok = rnd_q >= 4'd1 && rnd_q <= NR_L;
    assign last   = rnd_q == NR_L;
    assign sr     = shift_rows(sub_bytes(blk_q));
    assign res    = (last ? sr : mix_columns(sr)) ^ key_nxt;

    always_ff @(posedge clk) fsm_q <= reset ? IDLE : fsm_d;

    // an out-of-range round count falls back to IDLE rather than continuing
    always_comb begin
        fsm_d = fsm_q;
        case (fsm_q)
            IDLE:    fsm_d = accept ? ROUND : IDLE;
            ROUND:   fsm_d = !rnd_ok ? IDLE : last ? DONE : ROUND;
            DONE:    fsm_d = out_ready ? IDLE : DONE;
            default: fsm_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = fsm_q == IDLE && !reset;
        busy      = fsm_q == ROUND;
        out_valid = fsm_q == DONE;
        data_out  = dout_q;
    end

    always_comb begin
        blk_d  = blk_q;
        key_d  = key_q;
        rcon_d = rcon_q;
        rnd_d  = rnd_q;
        dout_d = dout_q;
        if (accept) begin
            blk_d  = data_in ^ key;
            key_d  = key;
            rcon_d = RCON_INIT;
            rnd_d  = 4'd1;
        end else if (fsm_q == ROUND) begin
            blk_d  = res;
            key_d  = key_nxt;
            rcon_d = xtime(rcon_q);
            rnd_d  = rnd_ok ? rnd_q + 4'd1 : 4'd0;
            dout_d = last ? res : dout_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            blk_q  <= '0;
            key_q  <= '0;
            rcon_q <= '0;
            rnd_q  <= '0;
            dout_q <= '0;
        end else begin
            blk_q  <= blk_d;
            key_q  <= key_d;
            rcon_q <= rcon_d;
            rnd_q  <= rnd_d;
            dout_q <= dout_d;
        end
    end

`ifdef AES_ROUND_SCHEDULER_STATS_EN
    logic [31:0] blocks_q;
    always_ff @(posedge clk) blocks_q <= reset ? '0 : blocks_q + 32'(out_valid && out_ready);
    assign blocks_done = blocks_q;
`endif

endmodule
